// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA timing generator.
//   - Default 640x480@60 raster constants (H_*/V_* and totals).
//   - Coordinate and colour widths.
//   - rgb_t pixel struct, sync_bus_t delay-line payload.
//   - bar_rgb(): colour-bar helper used when VGA_TEST_PATTERN_EN is defined.
package vga_pkg;

  localparam int COORD_W = 10;
  localparam int COLOR_W = 4;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  typedef struct packed {
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
  } rgb_t;

  typedef struct packed {
    logic               hs;
    logic               vs;
    logic               act;
    logic [COORD_W-1:0] h;
  } sync_bus_t;

  // 8 bars of 80 px; bar index bits 2/1/0 select full-scale R/G/B.
  function automatic rgb_t bar_rgb(input logic [COORD_W-1:0] x);
    logic [COORD_W-1:0] idx;
    rgb_t               c;
    idx     = x / COORD_W'(80);
    c.red   = idx[2] ? '1 : '0;
    c.green = idx[1] ? '1 : '0;
    c.blue  = idx[0] ? '1 : '0;
    return c;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Fixed-depth delay line for {hs, vs, act, h_cnt}, used to realign sync and
// blanking with renderer colour that arrives DEPTH cycles after coordinates.
// DEPTH = 0 is a pure wire. Reset loads inactive values (sync idle, act low).
// Ports:
//   clk, reset         pixel clock, synchronous active-high reset
//   hs, vs, act, h_cnt raw signals from the counters
//   hs_d..h_d          the same signals DEPTH cycles later
module vga_sync_delay
  import vga_pkg::*;
#(
  parameter int   DEPTH    = 1,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hs,
  input  logic               vs,
  input  logic               act,
  input  logic [COORD_W-1:0] h_cnt,
  output logic               hs_d,
  output logic               vs_d,
  output logic               act_d,
  output logic [COORD_W-1:0] h_d
);

  localparam sync_bus_t IDLE = '{hs: ~SYNC_POL, vs: ~SYNC_POL, act: 1'b0, h: '0};

  sync_bus_t din, dout;

  assign din = '{hs: hs, vs: vs, act: act, h: h_cnt};

  generate
    if (DEPTH == 0) begin : g_wire
      assign dout = din;
    end else begin : g_pipe
      sync_bus_t pipe [DEPTH];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) pipe[i] <= IDLE;
        end else begin
          pipe[0] <= din;
          for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign dout = pipe[DEPTH-1];
    end
  endgenerate

  assign hs_d  = dout.hs;
  assign vs_d  = dout.vs;
  assign act_d = dout.act;
  assign h_d   = dout.h;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (640x480@60 by default).
// Free-running h/v counters drive x_o/y_o to the renderer; renderer colour
// comes back IN_LATENCY cycles later, so sync/blanking are delayed by the
// same amount and everything leaves through one output register
// (IN_LATENCY+1 cycles from counter state to pins).
// Optional build macro VGA_TEST_PATTERN_EN: adds test_en_i, which replaces
// renderer colour with 8 vertical 80-px colour bars.
// Ports:
//   clk_i, reset_i            pixel clock, synchronous active-high reset
//   red_i/green_i/blue_i      renderer colour
//   x_o, y_o, frame_start_o   counter state (undelayed) and frame pulse
//   red_o/green_o/blue_o      registered, blanked colour to DAC
//   hsync_o, vsync_o          registered sync to monitor
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_VISIBLE  = H_VISIBLE_DEF,
  parameter int   H_FRONT    = H_FRONT_DEF,
  parameter int   H_SYNC     = H_SYNC_DEF,
  parameter int   H_BACK     = H_BACK_DEF,
  parameter int   V_VISIBLE  = V_VISIBLE_DEF,
  parameter int   V_FRONT    = V_FRONT_DEF,
  parameter int   V_SYNC     = V_SYNC_DEF,
  parameter int   V_BACK     = V_BACK_DEF,
  parameter logic SYNC_POL   = 1'b0,
  parameter int   IN_LATENCY = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
`ifdef VGA_TEST_PATTERN_EN
  input  logic               test_en_i,
`endif
  input  logic [COLOR_W-1:0] red_i,
  input  logic [COLOR_W-1:0] green_i,
  input  logic [COLOR_W-1:0] blue_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               frame_start_o,
  output logic [COLOR_W-1:0] red_o,
  output logic [COLOR_W-1:0] green_o,
  output logic [COLOR_W-1:0] blue_o,
  output logic               hsync_o,
  output logic               vsync_o
);

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_VISIBLE + H_FRONT);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_VISIBLE + V_FRONT);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_VISIBLE);
  localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_VISIBLE);

  logic [COORD_W-1:0] h_cnt, v_cnt;
  logic               h_wrap;

  assign h_wrap = (h_cnt == H_LAST);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign x_o           = h_cnt;
  assign y_o           = v_cnt;
  assign frame_start_o = (h_cnt == '0) && (v_cnt == '0) && !reset_i;

  // Raw sync/active, referenced to the current counter state.
  logic hs_raw, vs_raw, act_raw;

  assign hs_raw  = (h_cnt >= HS_START && h_cnt < HS_END) ? SYNC_POL : ~SYNC_POL;
  assign vs_raw  = (v_cnt >= VS_START && v_cnt < VS_END) ? SYNC_POL : ~SYNC_POL;
  assign act_raw = (h_cnt < H_VIS) && (v_cnt < V_VIS);

  logic               hs_d, vs_d, act_d;
  logic [COORD_W-1:0] h_d;

  vga_sync_delay #(
    .DEPTH    (IN_LATENCY),
    .SYNC_POL (SYNC_POL)
  ) u_sync_delay (
    .clk   (clk_i),
    .reset (reset_i),
    .hs    (hs_raw),
    .vs    (vs_raw),
    .act   (act_raw),
    .h_cnt (h_cnt),
    .hs_d  (hs_d),
    .vs_d  (vs_d),
    .act_d (act_d),
    .h_d   (h_d)
  );

  rgb_t pix;

`ifdef VGA_TEST_PATTERN_EN
  // Bars are indexed on the delayed h_cnt so they line up with act_d.
  always_comb begin
    pix = '{red: red_i, green: green_i, blue: blue_i};
    if (test_en_i) pix = bar_rgb(h_d);
  end
`else
  logic h_d_unused;
  assign h_d_unused = ^h_d;

  always_comb begin
    pix = '{red: red_i, green: green_i, blue: blue_i};
  end
`endif

  rgb_t rgb_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rgb_q   <= '0;
      hsync_o <= ~SYNC_POL;
      vsync_o <= ~SYNC_POL;
    end else begin
      rgb_q   <= act_d ? pix : '0;
      hsync_o <= hs_d;
      vsync_o <= vs_d;
    end
  end

  assign red_o   = rgb_q.red;
  assign green_o = rgb_q.green;
  assign blue_o  = rgb_q.blue;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen. Horizontal timing is the real
// 800-clock line; the vertical timing is shrunk to 15 lines (8 visible,
// front 2, sync 2, back 3) so several frames and a mid-vsync reset fit in
// a short run. The reference model works from the cycle count t since the
// last reset: counters are t mod line/frame, pins are the rules applied to
// the counter state of t-2 and the colour driven during t-1.
module tb_vga_timing_gen;

  localparam int HV = 640, HF = 16, HS = 96, HB = 48;
  localparam int VV = 8, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  // Second frame-two-lines into the vsync pulse (second sync line), h=700.
  localparam int RST_T = 2 * FRAME + (VV + VF + 1) * HT + 700;

  logic       clk = 1'b0;
  logic       reset_i;
  logic [3:0] red_i, green_i, blue_i;
  logic [9:0] x_o, y_o;
  logic       frame_start_o;
  logic [3:0] red_o, green_o, blue_o;
  logic       hsync_o, vsync_o;
  logic       test_en = 1'b0;

  vga_timing_gen #(
    .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
    .SYNC_POL  (1'b0), .IN_LATENCY (1)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
`ifdef VGA_TEST_PATTERN_EN
    .test_en_i     (test_en),
`endif
    .red_i         (red_i),
    .green_i       (green_i),
    .blue_i        (blue_i),
    .x_o           (x_o),
    .y_o           (y_o),
    .frame_start_o (frame_start_o),
    .red_o         (red_o),
    .green_o       (green_o),
    .blue_o        (blue_o),
    .hsync_o       (hsync_o),
    .vsync_o       (vsync_o)
  );

  always #20 clk = ~clk;

  int          t = 0;
  bit          known = 1'b0;
  int          nrst = 0;
  int          checks = 0;
  int          failures = 0;
  logic [12:0] hist [4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0d nrst=%0d got=%0h want=%0h", name, t, nrst, act, exp);
    end
  endtask

  function automatic int bar(input int hp);
    int i;
    i = hp / 80;
    return (((i & 4) != 0) ? 12'hF00 : 0) | (((i & 2) != 0) ? 12'h0F0 : 0) |
           (((i & 1) != 0) ? 12'h00F : 0);
  endfunction

  // Compare process: every cycle after the first reset.
  always @(negedge clk) begin
    if (known) begin
      int h, v, tp, hp, vp, e_rgb, e_hs, e_vs, pins;
      bit act;
      logic [12:0] prev;
      h = t % HT;
      v = (t / HT) % VT;
      chk("x_o", int'(x_o), h);
      chk("y_o", int'(y_o), v);
      chk("frame_start", int'(frame_start_o), (h == 0 && v == 0 && !reset_i) ? 1 : 0);

      if (t < 2) begin
        e_rgb = 0; e_hs = 1; e_vs = 1;
      end else begin
        tp   = t - 2;
        hp   = tp % HT;
        vp   = (tp / HT) % VT;
        act  = (hp < HV) && (vp < VV);
        e_hs = (hp >= HV + HF && hp < HV + HF + HS) ? 0 : 1;
        e_vs = (vp >= VV + VF && vp < VV + VF + VS) ? 0 : 1;
        prev = hist[(t - 1) % 4];
        if (!act)        e_rgb = 0;
        else if (prev[12]) e_rgb = bar(hp);
        else             e_rgb = int'(prev[11:0]);
      end
      pins = int'({red_o, green_o, blue_o});
      chk("rgb", pins, e_rgb);
      chk("hsync", int'(hsync_o), e_hs);
      chk("vsync", int'(vsync_o), e_vs);

      // Hand-computed anchors for the model.
      case (t)
        0: if (nrst == 2) begin
          chk("rst_mid_x", int'(x_o), 0);
          chk("rst_mid_y", int'(y_o), 0);
          chk("rst_mid_hs", int'(hsync_o), 1);
          chk("rst_mid_vs", int'(vsync_o), 1);
          chk("rst_mid_rgb", pins, 0);
        end else chk("rst_fs", int'(frame_start_o), 1);
        2:    chk("lit_red_px0", int'(red_o), 0);
        7:    chk("lit_red_px5", int'(red_o), 5);
        641:  chk("lit_red_px639", int'(red_o), 15);
        642:  chk("lit_red_blank", int'(red_o), 0);
        657:  chk("lit_hs_pre", int'(hsync_o), 1);
        658:  chk("lit_hs_first", int'(hsync_o), 0);
        753:  chk("lit_hs_last", int'(hsync_o), 0);
        754:  chk("lit_hs_end", int'(hsync_o), 1);
        801:  chk("lit_f_pre", pins, 0);
        802:  chk("lit_f_first", pins, 12'hFFF);
        1441: chk("lit_f_last", pins, 12'hFFF);
        1442: chk("lit_f_post", pins, 0);
        1458: chk("lit_hs_line1", int'(hsync_o), 0);
        default: ;
      endcase
      if (nrst == 1) begin
        case (t)
          8001:  chk("lit_vs_pre", int'(vsync_o), 1);
          8002:  chk("lit_vs_first", int'(vsync_o), 0);
          9601:  chk("lit_vs_last", int'(vsync_o), 0);
          9602:  chk("lit_vs_end", int'(vsync_o), 1);
          11999: chk("lit_fs_pre", int'(frame_start_o), 0);
          12000: chk("lit_fs_frame1", int'(frame_start_o), 1);
          RST_T: begin
            chk("lit_mid_hs_low", int'(hsync_o), 0);
            chk("lit_mid_vs_low", int'(vsync_o), 0);
          end
`ifdef VGA_TEST_PATTERN_EN
          4087: chk("lit_tp_px85", pins, 12'h00F);
          4641: chk("lit_tp_px639", pins, 12'hFFF);
          4642: chk("lit_tp_blank", pins, 0);
`endif
          default: ;
        endcase
      end
      hist[t % 4] = {test_en, red_i, green_i, blue_i};
    end
  end

  // Driver: phases chosen by t so the anchors above are deterministic.
  initial begin
    logic [9:0] px;
    px      = '0;
    reset_i = 1'b1;
    red_i   = '0; green_i = '0; blue_i = '0;
    repeat (3) @(posedge clk);
    while (1) begin
      @(posedge clk);
      if (reset_i) begin
        t     = 0;
        known = 1'b1;
        nrst++;
      end else t++;
      if (nrst == 2 && t == 3000) break;
      #1;
      reset_i = (nrst == 1 && t == RST_T);
      if (t < 780) begin
        // renderer returning x of the previous cycle in red
        red_i   = px[3:0];
        green_i = 4'($urandom);
        blue_i  = 4'($urandom);
      end else if (t < 2400) begin
        red_i = 4'hF; green_i = 4'hF; blue_i = 4'hF;
      end else begin
        red_i   = 4'($urandom);
        green_i = 4'($urandom);
        blue_i  = 4'($urandom);
      end
`ifdef VGA_TEST_PATTERN_EN
      test_en = (t >= 3990 && t < 5600);
`endif
      px = x_o;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
